// File: rtl/convergence_pkg.sv
// convergence_pkg
// Shared definitions for the convergence monitor:
//   - conv_state_t : monitor FSM state encoding
//   - DEFAULT_THRESHOLD : 1.0 expressed in Q8.8
package convergence_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam logic [15:0] DEFAULT_THRESHOLD = 16'h0100;

endpackage

// File: rtl/conv_lane.sv
// conv_lane
// Per-parameter change metric and threshold compare.
// Ports:
//   param     in  DATA_W  current signed value
//   prev      in  DATA_W  previously accepted signed value
//   step      in  DATA_W  signed step size
//   use_step  in  1       1: metric = |step|, 0: metric = |param - prev|
//   threshold in  DATA_W  unsigned pass threshold
//   metric    out DATA_W  unsigned magnitude of the selected change measure
//   pass      out 1       metric strictly below threshold
module conv_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] param,
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] step,
  input  logic              use_step,
  input  logic [DATA_W-1:0] threshold,
  output logic [DATA_W-1:0] metric,
  output logic              pass
);

  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   diff_mag;
  logic [DATA_W-1:0] diff_metric;
  logic [DATA_W-1:0] step_mag;

  // Difference taken one bit wider than the operands so opposite-sign
  // extremes (e.g. 0x7FFF vs 0x8000) cannot wrap.
  assign diff     = {param[DATA_W-1], param} - {prev[DATA_W-1], prev};
  assign diff_mag = diff[DATA_W] ? (~diff + {{DATA_W{1'b0}}, 1'b1}) : diff;

  // A magnitude that does not fit in DATA_W bits clips to all ones.
  assign diff_metric = diff_mag[DATA_W] ? {DATA_W{1'b1}} : diff_mag[DATA_W-1:0];

  // Read as unsigned, the negation of the most negative step is exactly
  // its magnitude, so no saturation is needed here.
  assign step_mag = step[DATA_W-1] ? (~step + {{(DATA_W-1){1'b0}}, 1'b1}) : step;

  assign metric = use_step ? step_mag : diff_metric;
  assign pass   = (metric < threshold);

endmodule

// File: rtl/convergence_monitor.sv
// convergence_monitor
// Watches a vector of fixed-point parameters sample by sample and decides
// when they have settled (every lane below threshold for `patience`
// consecutive samples) or when the sample budget MAX_ITER is spent.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin a new run (latches threshold/patience/method)
//   sample_valid     a sample is presented this cycle
//   params_flat      NUM_PARAMS signed values, lane i at [i*DATA_W +: DATA_W]
//   steps_flat       NUM_PARAMS signed step sizes, same packing
//   use_step_method  1: judge by |step|, 0: judge by |param - prev|
//   threshold        unsigned per-lane pass threshold
//   patience         consecutive passing samples required (0 acts as 1)
//   busy, done       run in progress / run finished
//   converged        run ended by convergence
//   timeout          run ended by exhausting MAX_ITER samples
//   iter_count       accepted samples in this run
//   streak           current run of consecutive passing samples
//   max_change       largest lane metric of the last evaluated sample
//   max_idx          lane holding max_change (lowest index on ties)
module convergence_monitor
  import convergence_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int DATA_W     = 16,
  parameter int MAX_ITER   = 50,
  parameter int PATIENCE_W = 4,
  localparam int ITER_W    = $clog2(MAX_ITER + 1),
  localparam int IDX_W     = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic [NUM_PARAMS*DATA_W-1:0] params_flat,
  input  logic [NUM_PARAMS*DATA_W-1:0] steps_flat,
  input  logic                         use_step_method,
  input  logic [DATA_W-1:0]            threshold,
  input  logic [PATIENCE_W-1:0]        patience,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic                         timeout,
  output logic [ITER_W-1:0]            iter_count,
  output logic [PATIENCE_W-1:0]        streak,
  output logic [DATA_W-1:0]            max_change,
  output logic [IDX_W-1:0]             max_idx
);

  conv_state_t state_reg, state_next;

  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         converged_reg, converged_next;
  logic                         timeout_reg, timeout_next;
  logic [ITER_W-1:0]            iter_reg, iter_next;
  logic [PATIENCE_W-1:0]        streak_reg, streak_next;
  logic [DATA_W-1:0]            max_change_reg, max_change_next;
  logic [IDX_W-1:0]             max_idx_reg, max_idx_next;
  logic [NUM_PARAMS*DATA_W-1:0] prev_reg, prev_next;
  logic [DATA_W-1:0]            threshold_reg, threshold_next;
  logic [PATIENCE_W-1:0]        patience_reg, patience_next;
  logic                         use_step_reg, use_step_next;

  logic [DATA_W-1:0]     lane_metric [NUM_PARAMS];
  logic [NUM_PARAMS-1:0] lane_pass;
  logic [DATA_W-1:0]     top_metric;
  logic [IDX_W-1:0]      top_lane;
  logic [PATIENCE_W-1:0] eff_patience;

  generate
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_lane
      conv_lane #(.DATA_W(DATA_W)) u_lane (
        .param     (params_flat[gi*DATA_W +: DATA_W]),
        .prev      (prev_reg[gi*DATA_W +: DATA_W]),
        .step      (steps_flat[gi*DATA_W +: DATA_W]),
        .use_step  (use_step_reg),
        .threshold (threshold_reg),
        .metric    (lane_metric[gi]),
        .pass      (lane_pass[gi])
      );
    end
  endgenerate

  // Argmax over lanes; strict '>' keeps the lowest index on ties.
  always_comb begin
    top_metric = lane_metric[0];
    top_lane   = '0;
    for (int i = 1; i < NUM_PARAMS; i++) begin
      if (lane_metric[i] > top_metric) begin
        top_metric = lane_metric[i];
        top_lane   = IDX_W'(i);
      end
    end
  end

  assign eff_patience = (patience_reg == '0) ? PATIENCE_W'(1) : patience_reg;

  always_comb begin
    logic evaluate;
    logic conv_hit;
    logic [PATIENCE_W-1:0] streak_upd;

    state_next      = state_reg;
    converged_next  = converged_reg;
    timeout_next    = timeout_reg;
    iter_next       = iter_reg;
    streak_next     = streak_reg;
    max_change_next = max_change_reg;
    max_idx_next    = max_idx_reg;
    prev_next       = prev_reg;
    threshold_next  = threshold_reg;
    patience_next   = patience_reg;
    use_step_next   = use_step_reg;
    evaluate        = 1'b0;
    conv_hit        = 1'b0;
    streak_upd      = streak_reg;

    if (start) begin
      state_next      = PRIME;
      converged_next  = 1'b0;
      timeout_next    = 1'b0;
      iter_next       = '0;
      streak_next     = '0;
      max_change_next = '0;
      max_idx_next    = '0;
      prev_next       = '0;
      threshold_next  = threshold;
      patience_next   = patience;
      use_step_next   = use_step_method;
    end else if (sample_valid && (state_reg == PRIME || state_reg == RUN)) begin
      prev_next = params_flat;
      if (iter_reg != ITER_W'(MAX_ITER)) begin
        iter_next = iter_reg + ITER_W'(1);
      end

      // The first diff-method sample has no valid predecessor, so it only
      // primes the prev store.
      evaluate = !(state_reg == PRIME && !use_step_reg);

      if (evaluate) begin
        if (&lane_pass) begin
          streak_upd = (streak_reg == '1) ? streak_reg : streak_reg + PATIENCE_W'(1);
        end else begin
          streak_upd = '0;
        end
        streak_next     = streak_upd;
        max_change_next = top_metric;
        max_idx_next    = top_lane;
        conv_hit        = (streak_upd >= eff_patience);
      end

      if (conv_hit) begin
        converged_next = 1'b1;
        state_next     = DONE;
      end else if (iter_next == ITER_W'(MAX_ITER)) begin
        timeout_next = 1'b1;
        state_next   = DONE;
      end else begin
        state_next = RUN;
      end
    end

    busy_next = (state_next == PRIME) || (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      converged_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
      iter_reg       <= '0;
      streak_reg     <= '0;
      max_change_reg <= '0;
      max_idx_reg    <= '0;
      prev_reg       <= '0;
      threshold_reg  <= '0;
      patience_reg   <= '0;
      use_step_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      converged_reg  <= converged_next;
      timeout_reg    <= timeout_next;
      iter_reg       <= iter_next;
      streak_reg     <= streak_next;
      max_change_reg <= max_change_next;
      max_idx_reg    <= max_idx_next;
      prev_reg       <= prev_next;
      threshold_reg  <= threshold_next;
      patience_reg   <= patience_next;
      use_step_reg   <= use_step_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign converged  = converged_reg;
  assign timeout    = timeout_reg;
  assign iter_count = iter_reg;
  assign streak     = streak_reg;
  assign max_change = max_change_reg;
  assign max_idx    = max_idx_reg;

endmodule

// File: doc/convergence_monitor.md
CONVERGENCE_MONITOR -- requirements
Module: convergence_monitor

Interface
REQ-001 SHALL have parameter NUM_PARAMS, default 4: number of monitored parameters, range 1..16.
REQ-002 SHALL have parameter DATA_W, default 16: signed fixed-point word width (Q8.8 at default).
REQ-003 SHALL have parameter MAX_ITER, default 50: sample budget before timeout.
REQ-004 SHALL have parameter PATIENCE_W, default 4: width of patience input.
REQ-005 Ports SHALL be: clk in 1 clock; rst_n in 1 async active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 start in 1: begin new run; sample_valid in 1: one sample presented this cycle.
REQ-007 params_flat in NUM_PARAMS*DATA_W: signed current values, lane i at bits [i*DATA_W +: DATA_W]; steps_flat in NUM_PARAMS*DATA_W: signed step sizes, same packing.
REQ-008 use_step_method in 1; threshold in DATA_W unsigned; patience in PATIENCE_W: consecutive passing samples required.
REQ-009 Outputs: busy 1; done 1; converged 1; timeout 1; iter_count clog2(MAX_ITER+1); streak PATIENCE_W; max_change DATA_W unsigned; max_idx max(1,clog2(NUM_PARAMS)).

Function
REQ-010 FSM states SHALL be IDLE, PRIME, RUN, DONE; busy=1 in PRIME/RUN, done=1 in DONE only.
REQ-011 start=1 in any state SHALL clear iter_count, streak, max_change, max_idx, converged, timeout, and prev store, latch threshold, patience, use_step_method, and enter PRIME next cycle.
REQ-012 start and sample_valid in the same cycle: start wins, sample ignored.
REQ-013 sample_valid in IDLE or DONE SHALL be ignored with no output change.
REQ-014 Every accepted sample (PRIME or RUN) SHALL store params as prev and increment iter_count (saturating at MAX_ITER).
REQ-015 Per-lane metric: step method = |step_i|; diff method = |param_i - prev_i| computed at DATA_W+1 bits, saturated to 2^DATA_W-1.
REQ-016 Lane passes iff metric < latched threshold (strict); sample passes iff all lanes pass.
REQ-017 In PRIME, diff method SHALL skip evaluation (streak unchanged) and go to RUN; step method SHALL evaluate, then go to RUN unless terminated.
REQ-018 Evaluated sample: pass -> streak+1 (saturating at 2^PATIENCE_W-1); fail -> streak=0.
REQ-019 max_change/max_idx SHALL update on every evaluated sample to the largest lane metric; ties resolve to the lowest index.
REQ-020 Convergence: after update, streak >= max(patience,1) -> converged=1, go to DONE.
REQ-021 Timeout: iter_count reaching MAX_ITER without convergence -> timeout=1, go to DONE; simultaneous convergence SHALL take priority (timeout=0).
REQ-022 All outputs SHALL be registered; results visible the cycle after sample acceptance (latency 1).
REQ-023 converged/timeout SHALL hold in DONE until the next start.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE with every output and internal register zero.
REQ-025 Reset mid-run SHALL discard the run; no sample is accepted until the next start.

Structure
REQ-026 Shared package convergence_pkg SHALL hold the FSM state enum and the default threshold constant 1.0 in Q8.8 (16'h0100).
REQ-027 Per-lane abs/compare logic SHALL be sub-module conv_lane, instantiated NUM_PARAMS times by generate; the max/argmax tree stays in the top.

Verification
REQ-028 Diff method, threshold 0x0100, patience 2, a lane sequence 0x0000, 0x0400, 0x0480, 0x04C0 with other lanes constant -> streak 0,0,1,2, converged=1 one cycle after the 4th sample, iter_count=4.
REQ-029 Step method, patience 1, all steps 0x00FF on the first sample -> converged after one sample; a step of 0x0100 on lane 2 -> fail, max_idx=2.
REQ-030 Fail streak with MAX_ITER=50 -> timeout=1 after 50th sample; 50th sample also passing to patience -> converged=1, timeout=0.
REQ-031 Lane 0 = 0x7FFF then 0x8000 (diff method) -> max_change=0xFFFF, sample fails.
REQ-032 start asserted together with sample_valid while in RUN -> counters cleared, sample ignored; rst_n pulsed mid-run -> IDLE, all outputs 0, samples ignored until start.
